pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_rst_pkg.sv | 14 +
 rtl/sync_bit.sv | 18 +
 rtl/pll_reset_sequencer.sv | 78 +++++++
 3 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: FSM encoding, loss-counter width and default parameters shared by pll_reset_sequencer.
package pll_rst_pkg;
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;
  localparam int LOSS_CNT_W             = 8;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_NUM_STAGES         = 3;
  localparam int DEF_STAGE_GAP_CYCLES   = 16;
  localparam int DEF_SYNC_DEPTH         = 2;
endpackage

// File: rtl/sync_bit.sv
// sync_bit: SYNC_DEPTH-flop synchronizer for one asynchronous bit, async active-low reset to 0.
module sync_bit
  import pll_rst_pkg::*;
#(
  parameter int SYNC_DEPTH = DEF_SYNC_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  assign sync_d = {sync_q[SYNC_DEPTH-2:0], d};
  assign q = sync_q[SYNC_DEPTH-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: releases staged resets once PLL lock has been stable; the lock-loss
// counter exists only when PLL_RESET_SEQUENCER_LOSS_CNT_EN is defined (otherwise tied to 0).
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int NUM_STAGES         = DEF_NUM_STAGES,
  parameter int STAGE_GAP_CYCLES   = DEF_STAGE_GAP_CYCLES,
  parameter int SYNC_DEPTH         = DEF_SYNC_DEPTH
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  PLL_LOCK,
  input  logic                  SW_RST_REQ,
  output logic [NUM_STAGES-1:0] RST_N_OUT,
  output logic                  SEQ_DONE,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [1:0]            STATE
);
  localparam int CW = $clog2(LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES ?
                             LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES) + 1;
  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] rst_q, rst_d, rst_step;
  logic                  lock_sync;
  sync_bit #(.SYNC_DEPTH(SYNC_DEPTH)) u_sync (
    .clk  (CLK),
    .rst_n(RESETN),
    .d    (PLL_LOCK),
    .q    (lock_sync)
  );
  // Thermometer step: yields bit 0 from all-zero, then fills upward one stage at a time.
  assign rst_step = (rst_q << 1) | NUM_STAGES'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    if (state_q != WAIT_LOCK && (!lock_sync || SW_RST_REQ)) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
      rst_d   = '0;
    end else if (state_q == WAIT_LOCK) begin
      state_d = lock_sync ? STABLE : WAIT_LOCK;
      cnt_d   = '0;
    end else if (state_q != RUN) begin
      if (cnt_q == (state_q == STABLE ? CW'(LOCK_STABLE_CYCLES - 1) : CW'(STAGE_GAP_CYCLES - 1))) begin
        rst_d   = rst_step;
        cnt_d   = '0;
        state_d = &rst_step ? RUN : RELEASE;
      end else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  assign RST_N_OUT = rst_q;
  assign SEQ_DONE  = state_q == RUN;
  assign STATE     = state_q;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  lost;
  assign lost   = !lock_sync && (state_q == RELEASE || state_q == RUN);
  assign loss_d = (lost && loss_q != '1) ? loss_q + LOSS_CNT_W'(1) : loss_q;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) loss_q <= '0;
    else loss_q <= loss_d;
  assign LOCK_LOSS_CNT = loss_q;
`else
  assign LOCK_LOSS_CNT = '0;
`endif
endmodule
